tap_pattern_player: RTL and testbench

- Inverse of the debounced tap counter: takes a tap count and plays it back as a train of LED/buzzer pulses.
- Output: N on-pulses separated by off-gaps, then a trailing quiet window, then a one-cycle done.
- Sits after the tap counter (echo/confirm of the count) or drives a status LED from any count source.
- The trailing window gives a reader or a downstream tap counter the same inactivity timeout that delimits one sequence from the next.

---
 rtl/tap_pattern_player.sv | 130 +++++++++++++
 tb/tb_tap_pattern_player.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tap_pattern_player.sv
// Plays a latched tap count back as a train of LED pulses, followed by a quiet
// trailing window and a one-cycle done strobe.
module tap_pattern_player #(
  parameter int ON_CYCLES    = 12_500_000,
  parameter int OFF_CYCLES   = 12_500_000,
  parameter int TRAIL_CYCLES = 50_000_000,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] count_in,
  input  logic                   abort,
  output logic                   led,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] pulses_left,
  output logic                   done
);

  localparam int MAX_ON_OFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int MAX_CYCLES = (MAX_ON_OFF > TRAIL_CYCLES) ? MAX_ON_OFF : TRAIL_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [TW-1:0] ON_LAST    = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] TRAIL_LAST = TW'(TRAIL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_TRAIL
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [COUNT_WIDTH-1:0] pulses_q, pulses_d;
  logic                   led_q, led_d;
  logic                   done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      pulses_q <= '0;
      led_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pulses_q <= pulses_d;
      led_q    <= led_d;
      done_q   <= done_d;
    end
  end

  // Every state change clears the timer; abort outranks any timer expiry.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + TW'(1);
    pulses_d = pulses_q;
    led_d    = led_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        led_d   = 1'b0;
        if (start) begin
          if (count_in != '0) begin
            state_d  = S_ON;
            pulses_d = count_in;
            led_d    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ON: begin
        if (abort) begin
          state_d  = S_IDLE;
          timer_d  = '0;
          pulses_d = '0;
          led_d    = 1'b0;
        end else if (timer_q == ON_LAST) begin
          timer_d  = '0;
          led_d    = 1'b0;
          pulses_d = pulses_q - COUNT_WIDTH'(1);
          state_d  = (pulses_q == COUNT_WIDTH'(1)) ? S_TRAIL : S_OFF;
        end
      end
      S_OFF: begin
        if (abort) begin
          state_d  = S_IDLE;
          timer_d  = '0;
          pulses_d = '0;
          led_d    = 1'b0;
        end else if (timer_q == OFF_LAST) begin
          timer_d = '0;
          led_d   = 1'b1;
          state_d = S_ON;
        end
      end
      S_TRAIL: begin
        if (abort) begin
          state_d  = S_IDLE;
          timer_d  = '0;
          pulses_d = '0;
          led_d    = 1'b0;
        end else if (timer_q == TRAIL_LAST) begin
          timer_d = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        timer_d  = '0;
        pulses_d = '0;
        led_d    = 1'b0;
      end
    endcase
  end

  assign led         = led_q;
  assign busy        = (state_q != S_IDLE);
  assign pulses_left = pulses_q;
  assign done        = done_q;

endmodule

// File: tb/tb_tap_pattern_player.sv
// Directed bench for tap_pattern_player with short ON/OFF/TRAIL timings and
// per-cycle expected values derived from the pulse-train timing formula.
module tb_tap_pattern_player;

  localparam int ON_C  = 3;
  localparam int OFF_C = 2;
  localparam int TRL_C = 5;
  localparam int CW    = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] count_in;
  logic          abort;
  logic          led;
  logic          busy;
  logic [CW-1:0] pulses_left;
  logic          done;

  int checks   = 0;
  int failures = 0;

  tap_pattern_player #(
    .ON_CYCLES   (ON_C),
    .OFF_CYCLES  (OFF_C),
    .TRAIL_CYCLES(TRL_C),
    .COUNT_WIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .count_in   (count_in),
    .abort      (abort),
    .led        (led),
    .busy       (busy),
    .pulses_left(pulses_left),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Cycle c counts from the accepting edge (cycle 0) of an n-pulse run.
  task automatic checkCycle(input int n, input int c, input string tag);
    int period;
    int doneCycle;
    int completed;
    logic expLed;
    period    = ON_C + OFF_C;
    doneCycle = n * ON_C + (n - 1) * OFF_C + TRL_C + 1;
    expLed    = (c >= 1) && (((c - 1) / period) < n) && (((c - 1) % period) < ON_C);
    if (c < ON_C + 1) completed = 0;
    else begin
      completed = (c - (ON_C + 1)) / period + 1;
      if (completed > n) completed = n;
    end
    checkOutput({tag, ".led"}, 32'(led), 32'(expLed));
    checkOutput({tag, ".busy"}, 32'(busy), 32'((c >= 1) && (c < doneCycle)));
    checkOutput({tag, ".pulses"}, 32'(pulses_left), 32'((c >= 1) ? (n - completed) : 0));
    checkOutput({tag, ".done"}, 32'(done), 32'(c == doneCycle));
  endtask

  task automatic applyStimulus(input logic [CW-1:0] n);
    start    = 1'b1;
    count_in = n;
    advance();
    start    = 1'b0;
    count_in = 8'hA5;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".led"}, 32'(led), 32'd0);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
    checkOutput({tag, ".pulses"}, 32'(pulses_left), 32'd0);
    checkOutput({tag, ".done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    count_in = '0;
    repeat (3) advance();
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      checkIdle("reset_idle");
      advance();
    end

    // Three pulses with gaps and trailing window.
    applyStimulus(8'd3);
    for (int c = 1; c <= 22; c++) begin
      checkCycle(3, c, "n3");
      advance();
    end

    // Zero count: done next cycle, nothing else moves.
    applyStimulus(8'd0);
    checkOutput("n0.done", 32'(done), 32'd1);
    checkOutput("n0.led", 32'(led), 32'd0);
    checkOutput("n0.busy", 32'(busy), 32'd0);
    advance();
    checkIdle("n0_after");

    // Single pulse, then a start in the done cycle chains a new run.
    applyStimulus(8'd1);
    for (int c = 1; c <= 9; c++) begin
      checkCycle(1, c, "n1");
      if (c < 9) advance();
    end
    applyStimulus(8'd2);
    for (int c = 1; c <= 16; c++) begin
      checkCycle(2, c, "n2_chain");
      advance();
    end

    // Start while busy is ignored.
    applyStimulus(8'd2);
    for (int c = 1; c <= 16; c++) begin
      if (c == 4) begin
        start    = 1'b1;
        count_in = 8'd5;
      end
      checkCycle(2, c, "busy_start");
      advance();
      start = 1'b0;
    end

    // Abort in the middle of the second pulse.
    applyStimulus(8'd3);
    for (int c = 1; c <= 7; c++) begin
      if (c == 7) abort = 1'b1;
      checkCycle(3, c, "abort_pre");
      advance();
    end
    abort = 1'b0;
    for (int c = 8; c <= 26; c++) begin
      checkIdle("abort_post");
      advance();
    end

    // Abort together with start in idle: start wins.
    abort = 1'b1;
    applyStimulus(8'd1);
    abort = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      checkCycle(1, c, "abort_start");
      advance();
    end

    // Asynchronous reset in the middle of an ON pulse.
    applyStimulus(8'd4);
    advance();
    checkOutput("rst_pre.led", 32'(led), 32'd1);
    rst_n = 1'b0;
    #1;
    checkIdle("rst_async");
    repeat (2) advance();
    @(negedge clk);
    rst_n = 1'b1;
    advance();
    checkIdle("rst_release");
    applyStimulus(8'd4);
    for (int c = 1; c <= 26; c++) begin
      checkCycle(4, c, "n4_restart");
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
